// File: rtl/sgmii_clk_meas.sv
// rtl/sgmii_clk_meas.sv - gated edge-count measurement of MDC and GMII tx/rx clocks
module sgmii_clk_meas #(
    parameter int unsigned GATE_CYCLES   = 100000,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] exp_min,
    input  logic [31:0] exp_max,
    input  logic [31:0] mdc_cnt,
    input  logic [31:0] gmii_txclk_cnt,
    input  logic [31:0] gmii_rxclk_cnt,
    output logic [31:0] cnt_ctrl,
    output logic        busy,
    output logic        done,
    output logic [31:0] meas_mdc,
    output logic [31:0] meas_tx,
    output logic [31:0] meas_rx,
    output logic        tx_ok,
    output logic        rx_ok,
    output logic        mdc_alive
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE0 = 3'd1,
        ST_SNAP0   = 3'd2,
        ST_GATE    = 3'd3,
        ST_SETTLE1 = 3'd4,
        ST_SNAP1   = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // A zero-length parameter still yields a one-cycle state.
    localparam logic [31:0] GATE_LAST   = (GATE_CYCLES == 0)   ? 32'd0 : 32'(GATE_CYCLES - 1);
    localparam logic [31:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 32'd0 : 32'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [2:0]  cnt_en_q, cnt_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [31:0] mdc_r_q, mdc_r_d;
    logic [31:0] tx_r_q, tx_r_d;
    logic [31:0] rx_r_q, rx_r_d;
    logic [31:0] mdc_s_q, mdc_s_d;
    logic [31:0] tx_s_q, tx_s_d;
    logic [31:0] rx_s_q, rx_s_d;

    logic [31:0] meas_mdc_q, meas_mdc_d;
    logic [31:0] meas_tx_q, meas_tx_d;
    logic [31:0] meas_rx_q, meas_rx_d;
    logic        tx_ok_q, tx_ok_d;
    logic        rx_ok_q, rx_ok_d;
    logic        mdc_alive_q, mdc_alive_d;

    logic [31:0] delta_mdc, delta_tx, delta_rx;
    logic        settle_last, gate_last;

    // Modulo-2^32 subtraction makes counter wrap-around transparent.
    assign delta_mdc = mdc_r_q - mdc_s_q;
    assign delta_tx  = tx_r_q - tx_s_q;
    assign delta_rx  = rx_r_q - rx_s_q;

    assign settle_last = (timer_q == SETTLE_LAST);
    assign gate_last   = (timer_q == GATE_LAST);

    // Next-state selection; abort overrides every transition including start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_SETTLE0;
            ST_SETTLE0: if (settle_last) state_d = ST_SNAP0;
            ST_SNAP0:   state_d = ST_GATE;
            ST_GATE:    if (gate_last) state_d = ST_SETTLE1;
            ST_SETTLE1: if (settle_last) state_d = ST_SNAP1;
            ST_SNAP1:   state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    // Timer restarts at 0 on each state entry and rests at 0 in IDLE.
    always_comb begin
        timer_d = timer_q + 32'd1;
        if ((state_d != state_q) || (state_d == ST_IDLE)) begin
            timer_d = 32'd0;
        end
    end

    // Registered outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        cnt_en_d = (state_d == ST_GATE) ? 3'b111 : 3'b000;
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
    end

    // Input registering, start snapshots and result capture.
    always_comb begin
        mdc_r_d     = mdc_cnt;
        tx_r_d      = gmii_txclk_cnt;
        rx_r_d      = gmii_rxclk_cnt;
        mdc_s_d     = mdc_s_q;
        tx_s_d      = tx_s_q;
        rx_s_d      = rx_s_q;
        meas_mdc_d  = meas_mdc_q;
        meas_tx_d   = meas_tx_q;
        meas_rx_d   = meas_rx_q;
        tx_ok_d     = tx_ok_q;
        rx_ok_d     = rx_ok_q;
        mdc_alive_d = mdc_alive_q;
        if ((state_q == ST_SNAP0) && !abort) begin
            mdc_s_d = mdc_r_q;
            tx_s_d  = tx_r_q;
            rx_s_d  = rx_r_q;
        end
        if ((state_q == ST_SNAP1) && !abort) begin
            meas_mdc_d  = delta_mdc;
            meas_tx_d   = delta_tx;
            meas_rx_d   = delta_rx;
            // An inverted window (min > max) can never satisfy both bounds.
            tx_ok_d     = (exp_min <= delta_tx) && (delta_tx <= exp_max);
            rx_ok_d     = (exp_min <= delta_rx) && (delta_rx <= exp_max);
            mdc_alive_d = (delta_mdc != 32'd0);
        end
    end

    // State and control registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q  <= ST_IDLE;
            timer_q  <= 32'd0;
            cnt_en_q <= 3'b000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cnt_en_q <= cnt_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Datapath registers: input samples, snapshots and results.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            mdc_r_q     <= 32'd0;
            tx_r_q      <= 32'd0;
            rx_r_q      <= 32'd0;
            mdc_s_q     <= 32'd0;
            tx_s_q      <= 32'd0;
            rx_s_q      <= 32'd0;
            meas_mdc_q  <= 32'd0;
            meas_tx_q   <= 32'd0;
            meas_rx_q   <= 32'd0;
            tx_ok_q     <= 1'b0;
            rx_ok_q     <= 1'b0;
            mdc_alive_q <= 1'b0;
        end else begin
            mdc_r_q     <= mdc_r_d;
            tx_r_q      <= tx_r_d;
            rx_r_q      <= rx_r_d;
            mdc_s_q     <= mdc_s_d;
            tx_s_q      <= tx_s_d;
            rx_s_q      <= rx_s_d;
            meas_mdc_q  <= meas_mdc_d;
            meas_tx_q   <= meas_tx_d;
            meas_rx_q   <= meas_rx_d;
            tx_ok_q     <= tx_ok_d;
            rx_ok_q     <= rx_ok_d;
            mdc_alive_q <= mdc_alive_d;
        end
    end

    // Only the three enable bits are ever driven; counter-reset bits stay 0.
    assign cnt_ctrl  = {13'd0, cnt_en_q, 13'd0, 3'b000};
    assign busy      = busy_q;
    assign done      = done_q;
    assign meas_mdc  = meas_mdc_q;
    assign meas_tx   = meas_tx_q;
    assign meas_rx   = meas_rx_q;
    assign tx_ok     = tx_ok_q;
    assign rx_ok     = rx_ok_q;
    assign mdc_alive = mdc_alive_q;

endmodule

// File: tb/tb_sgmii_clk_meas.sv
// tb/tb_sgmii_clk_meas.sv - self-checking bench for sgmii_clk_meas
module tb_sgmii_clk_meas;

    localparam int G   = 100;
    localparam int S   = 4;
    localparam int LAT = 2 * S + G + 3;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] exp_min = 32'd0;
    logic [31:0] exp_max = 32'd0;
    logic [31:0] mdc_cnt = 32'd0;
    logic [31:0] gmii_txclk_cnt = 32'd0;
    logic [31:0] gmii_rxclk_cnt = 32'd0;
    logic [31:0] cnt_ctrl;
    logic        busy, done, tx_ok, rx_ok, mdc_alive;
    logic [31:0] meas_mdc, meas_tx, meas_rx;

    sgmii_clk_meas #(.GATE_CYCLES(G), .SETTLE_CYCLES(S)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .abort(abort),
        .exp_min(exp_min), .exp_max(exp_max), .mdc_cnt(mdc_cnt),
        .gmii_txclk_cnt(gmii_txclk_cnt), .gmii_rxclk_cnt(gmii_rxclk_cnt),
        .cnt_ctrl(cnt_ctrl), .busy(busy), .done(done), .meas_mdc(meas_mdc),
        .meas_tx(meas_tx), .meas_rx(meas_rx), .tx_ok(tx_ok), .rx_ok(rx_ok),
        .mdc_alive(mdc_alive)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;

    // Counter model settings, written only by the main process.
    int          run_seq = 0;
    logic [31:0] pre_tx = 0, pre_rx = 0, pre_mdc = 0;
    int          rate_tx = 1, rate_rx = 1, mdc_div = 4;
    bit          rand_mode = 0;
    // Counter model results, written only by the counter process.
    logic [31:0] sum_tx = 0, sum_rx = 0, sum_mdc = 0;
    int          ctrl_bad = 0;

    // Clock-counter block model: counts advance only in cycles where all enables are set.
    initial begin
        int seen_seq = 0;
        int en_idx = 0;
        int inc_tx, inc_rx;
        forever begin
            @(posedge ACLK);
            #2;
            if (run_seq != seen_seq) begin
                seen_seq = run_seq;
                en_idx = 0;
                gmii_txclk_cnt = pre_tx;
                gmii_rxclk_cnt = pre_rx;
                mdc_cnt = pre_mdc;
                sum_tx = 0;
                sum_rx = 0;
                sum_mdc = 0;
            end
            if ((cnt_ctrl & ~32'h0007_0000) != 32'd0) ctrl_bad++;
            if (cnt_ctrl[18:16] == 3'b111) begin
                inc_tx = rand_mode ? int'($urandom_range(0, 3)) : rate_tx;
                inc_rx = rand_mode ? int'($urandom_range(0, 3)) : rate_rx;
                gmii_txclk_cnt = gmii_txclk_cnt + 32'(inc_tx);
                gmii_rxclk_cnt = gmii_rxclk_cnt + 32'(inc_rx);
                sum_tx = sum_tx + 32'(inc_tx);
                sum_rx = sum_rx + 32'(inc_rx);
                if (mdc_div != 0 && (en_idx % mdc_div) == 0) begin
                    mdc_cnt = mdc_cnt + 32'd1;
                    sum_mdc = sum_mdc + 32'd1;
                end
                en_idx++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Call at a negedge; returns at the following negedge with start low.
    task automatic start_run(input logic [31:0] ptx, input logic [31:0] mn, input logic [31:0] mx);
        exp_min = mn;
        exp_max = mx;
        pre_tx = ptx;
        run_seq++;
        start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 400; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            @(negedge ACLK);
        end
    endtask

    task automatic chk_results(input string tag, input logic [31:0] etx, input logic [31:0] erx,
                               input logic [31:0] emdc, input logic etok, input logic erok,
                               input logic ealive);
        chk({tag, " meas_tx"}, meas_tx, etx);
        chk({tag, " meas_rx"}, meas_rx, erx);
        chk({tag, " meas_mdc"}, meas_mdc, emdc);
        chk({tag, " tx_ok"}, 32'(tx_ok), 32'(etok));
        chk({tag, " rx_ok"}, 32'(rx_ok), 32'(erok));
        chk({tag, " mdc_alive"}, 32'(mdc_alive), 32'(ealive));
    endtask

    typedef struct {
        logic [31:0] ptx;
        int          rtx, rrx, div;
        logic [31:0] mn, mx;
        logic [31:0] etx, erx, emdc;
        logic        etok, erok, ealive;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int lat, ndone, first;
        logic [31:0] mn, mx, etx, erx, emdc;

        vecs[0] = '{32'd0,         1, 1, 4,  98, 102, 100, 100,  25, 1, 1, 1};
        vecs[1] = '{32'hFFFF_FFD0, 1, 1, 4,  98, 102, 100, 100,  25, 1, 1, 1};
        vecs[2] = '{32'd0,         1, 0, 0,  98, 102, 100,   0,   0, 1, 0, 0};
        vecs[3] = '{32'd0,         1, 1, 4, 110,  90, 100, 100,  25, 0, 0, 1};
        vecs[4] = '{32'd0,         1, 1, 1, 100, 100, 100, 100, 100, 1, 1, 1};
        vecs[5] = '{32'd0,         2, 1, 2, 101, 200, 200, 100,  50, 1, 0, 1};
        vecs[6] = '{32'h1234_5678, 0, 1, 4,   0,   0,   0, 100,  25, 1, 0, 1};

        // Reset state
        #3;
        chk("rst cnt_ctrl", cnt_ctrl, 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk_results("rst", 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);

        // Table-driven measurements
        for (int v = 0; v < 7; v++) begin
            rate_tx = vecs[v].rtx;
            rate_rx = vecs[v].rrx;
            mdc_div = vecs[v].div;
            start_run(vecs[v].ptx, vecs[v].mn, vecs[v].mx);
            wait_done(lat);
            chk($sformatf("vec%0d latency", v), 32'(lat), 32'(LAT));
            chk_results($sformatf("vec%0d", v), vecs[v].etx, vecs[v].erx, vecs[v].emdc,
                        vecs[v].etok, vecs[v].erok, vecs[v].ealive);
            @(negedge ACLK);
            chk($sformatf("vec%0d done width", v), 32'(done), 32'd0);
            chk($sformatf("vec%0d busy after", v), 32'(busy), 32'd0);
        end

        // Abort in GATE cycle 50: results of vector 6 must survive
        rate_tx = 1; rate_rx = 1; mdc_div = 4;
        start_run(32'd0, 98, 102);
        repeat (54) @(negedge ACLK);
        chk("abort gate enables", cnt_ctrl, 32'h0007_0000);
        abort = 1'b1;
        @(negedge ACLK);
        abort = 1'b0;
        chk("abort cnt_ctrl", cnt_ctrl, 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        ndone = 0;
        for (int i = 0; i < 150; i++) begin
            if (done) ndone++;
            @(negedge ACLK);
        end
        chk("abort no done", 32'(ndone), 32'd0);
        chk_results("abort hold", 0, 100, 25, 1, 0, 1);

        // Start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge ACLK);
        start = 1'b0; abort = 1'b0;
        chk("start+abort busy", 32'(busy), 32'd0);
        ndone = 0;
        for (int i = 0; i < LAT + 10; i++) begin
            if (done) ndone++;
            @(negedge ACLK);
        end
        chk("start+abort no done", 32'(ndone), 32'd0);

        // Start re-pulsed during GATE is ignored
        start_run(32'd0, 98, 102);
        ndone = 0; first = -1;
        for (int i = 2; i < 300; i++) begin
            @(negedge ACLK);
            start = (i == 30);
            if (done) begin
                ndone++;
                if (first < 0) first = i;
            end
        end
        start = 1'b0;
        chk("restart first done", 32'(first), 32'(LAT));
        chk("restart done count", 32'(ndone), 32'd1);
        chk_results("restart", 100, 100, 25, 1, 1, 1);

        // Reset during GATE drops the enables asynchronously
        start_run(32'd0, 98, 102);
        repeat (49) @(negedge ACLK);
        chk("gate enables", cnt_ctrl, 32'h0007_0000);
        ARESET = 1'b1;
        #1;
        chk("async rst cnt_ctrl", cnt_ctrl, 32'd0);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);

        // Reset during SETTLE1 clears everything
        start_run(32'd0, 98, 102);
        repeat (106) @(negedge ACLK);
        chk("settle1 busy", 32'(busy), 32'd1);
        ARESET = 1'b1;
        #1;
        chk("rst2 cnt_ctrl", cnt_ctrl, 32'd0);
        chk("rst2 busy", 32'(busy), 32'd0);
        chk("rst2 done", 32'(done), 32'd0);
        chk_results("rst2", 0, 0, 0, 0, 0, 0);
        @(negedge ACLK);
        ARESET = 1'b0;

        // First start right after reset release is honoured
        start_run(32'hFFFF_FFF0, 98, 102);
        wait_done(lat);
        chk("post-rst latency", 32'(lat), 32'(LAT));
        chk_results("post-rst", 100, 100, 25, 1, 1, 1);
        @(negedge ACLK);

        // Randomized measurements against the increment-accumulating model
        rand_mode = 1;
        for (int t = 0; t < 20; t++) begin
            pre_rx  = $urandom;
            pre_mdc = $urandom;
            mdc_div = int'($urandom_range(0, 5));
            mn = 32'($urandom_range(0, 300));
            mx = 32'($urandom_range(0, 300));
            start_run($urandom, mn, mx);
            wait_done(lat);
            etx = sum_tx; erx = sum_rx; emdc = sum_mdc;
            chk($sformatf("rnd%0d latency", t), 32'(lat), 32'(LAT));
            chk_results($sformatf("rnd%0d", t), etx, erx, emdc,
                        (mn <= etx) && (etx <= mx), (mn <= erx) && (erx <= mx), emdc != 0);
            @(negedge ACLK);
        end

        chk("cnt_ctrl spare bits", 32'(ctrl_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
